// File: rtl/sa3_stream_bridge.sv
// rtl/sa3_stream_bridge.sv - byte-stream front end for the 3x3 systolic conv engine
// Loads a 25-byte frame, runs the engine through active/done, and streams back the 2x2 result.
module sa3_stream_bridge #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            active_sa3,
  output logic [16*DW-1:0] a_flat,
  output logic [9*DW-1:0] b_flat,
  input  logic            done_sa3,
  input  logic [DW-1:0]   c11,
  input  logic [DW-1:0]   c12,
  input  logic [DW-1:0]   c21,
  input  logic [DW-1:0]   c22,
  output logic            busy,
  output logic            err_frame,
  output logic            err_timeout
);

  localparam int RCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_UNLOAD} state_t;

  state_t                 state_q;
  logic [4:0]             k_q;
  logic [4:0]             k_d;
  logic [RCW-1:0]         rc_q;
  logic [RCW-1:0]         rc_d;
  logic [1:0]             j_q;
  logic [1:0]             j_d;
  logic [3:0][DW-1:0]     res_q;
  logic [16*DW-1:0]       a_q;
  logic [9*DW-1:0]        b_q;
  logic                   s_ready_q;
  logic                   m_valid_q;
  logic                   active_q;
  logic                   busy_q;
  logic                   err_frame_q;
  logic                   err_timeout_q;
  logic [3:0]             slot;
  logic                   frame_bad;

  assign k_d  = k_q + 5'd1;
  assign rc_d = rc_q + 1'b1;
  assign j_d  = j_q + 2'd1;
  // Bytes 16..24 land in filter slots 0..8, which is just the low nibble of k.
  assign slot = k_q[3:0];
  assign frame_bad = (s_last && (k_q != 5'd24)) || (!s_last && (k_q == 5'd24));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      k_q           <= '0;
      rc_q          <= '0;
      j_q           <= '0;
      res_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      s_ready_q     <= 1'b1;
      m_valid_q     <= 1'b0;
      active_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_frame_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            if (k_q < 5'd16) a_q[slot*DW +: DW] <= s_data;
            else             b_q[slot*DW +: DW] <= s_data;
            if (frame_bad) begin
              err_frame_q <= 1'b1;
              k_q         <= '0;
            end else if (s_last) begin
              state_q   <= ST_RUN;
              k_q       <= '0;
              rc_q      <= '0;
              s_ready_q <= 1'b0;
              active_q  <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              k_q <= k_d;
            end
          end
        end
        ST_RUN: begin
          if (done_sa3) begin
            res_q     <= {c22, c21, c12, c11};
            active_q  <= 1'b0;
            m_valid_q <= 1'b1;
            j_q       <= '0;
            state_q   <= ST_UNLOAD;
          end else if (rc_q == RCW'(TIMEOUT - 1)) begin
            // Abort after TIMEOUT active cycles; downstream still gets a full 4-byte result.
            err_timeout_q <= 1'b1;
            res_q         <= '0;
            active_q      <= 1'b0;
            m_valid_q     <= 1'b1;
            j_q           <= '0;
            state_q       <= ST_UNLOAD;
          end else begin
            rc_q <= rc_d;
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (j_q == 2'd3) begin
              state_q   <= ST_LOAD;
              j_q       <= '0;
              m_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              j_q <= j_d;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_valid_q ? res_q[j_q] : '0;
  assign m_last      = m_valid_q && (j_q == 2'd3);
  assign active_sa3  = active_q;
  assign a_flat      = a_q;
  assign b_flat      = b_q;
  assign busy        = busy_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sa3_stream_bridge.sv
// tb/tb_sa3_stream_bridge.sv - self-checking bench for sa3_stream_bridge
// Frame-level model plus per-cycle output compare and literal pins on nominal results.
module tb_sa3_stream_bridge;
  localparam int DW = 8;
  localparam int TIMEOUT = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0] s_data = '0;
  logic m_valid, m_ready = 1'b0, m_last;
  logic [7:0] m_data;
  logic active_sa3, done_sa3, busy, err_frame, err_timeout;
  logic [127:0] a_flat;
  logic [71:0] b_flat;
  logic [7:0] c11, c12, c21, c22;

  always #5 clk = ~clk;

  sa3_stream_bridge #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .active_sa3(active_sa3), .a_flat(a_flat), .b_flat(b_flat),
    .done_sa3(done_sa3), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Engine stub: done on the 17th active cycle, fixed results.
  int stub_cnt;
  bit stub_en = 1'b1;
  bit spur = 1'b0;
  logic [7:0] stub_c [4] = '{8'h09, 8'h12, 8'h1B, 8'h24};
  assign c11 = stub_c[0];
  assign c12 = stub_c[1];
  assign c21 = stub_c[2];
  assign c22 = stub_c[3];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt = 0;
      done_sa3 = 1'b0;
    end else begin
      if (active_sa3) stub_cnt++;
      else stub_cnt = 0;
      done_sa3 = spur || (stub_en && active_sa3 && stub_cnt == 17);
    end
  end

  // Frame-level reference model.
  typedef enum {P_LOAD, P_RUN, P_UNL} ph_t;
  ph_t ph;
  logic [7:0] ea [16];
  logic [7:0] eb [9];
  int nbytes, rc;
  bit ef, ef_n, eto;
  logic [7:0] outq [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_LOAD; nbytes = 0; rc = 0; ef = 0; eto = 0;
      outq.delete();
      for (int i = 0; i < 16; i++) ea[i] = '0;
      for (int i = 0; i < 9; i++) eb[i] = '0;
    end else begin
      ef_n = 0;
      case (ph)
        P_LOAD: if (s_valid) begin
          if (nbytes < 16) ea[nbytes] = s_data;
          else if (nbytes < 25) eb[nbytes-16] = s_data;
          nbytes++;
          if (s_last || nbytes == 25) begin
            if (s_last && nbytes == 25) begin ph = P_RUN; rc = 0; end
            else ef_n = 1;
            nbytes = 0;
          end
        end
        P_RUN: begin
          rc++;
          if (done_sa3) begin
            outq.push_back(c11); outq.push_back(c12);
            outq.push_back(c21); outq.push_back(c22);
            ph = P_UNL;
          end else if (rc == TIMEOUT) begin
            eto = 1;
            for (int i = 0; i < 4; i++) outq.push_back(8'h00);
            ph = P_UNL;
          end
        end
        P_UNL: if (m_ready) begin
          void'(outq.pop_front());
          if (outq.size() == 0) ph = P_LOAD;
        end
        default: ph = P_LOAD;
      endcase
      ef = ef_n;
    end
  end

  function automatic logic [127:0] pack_a();
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = ea[i];
    return r;
  endfunction

  function automatic logic [71:0] pack_b();
    logic [71:0] r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = eb[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_ready", s_ready, ph == P_LOAD);
      chk("busy", busy, ph != P_LOAD);
      chk("active_sa3", active_sa3, ph == P_RUN);
      chk("err_frame", err_frame, ef);
      chk("err_timeout", err_timeout, eto);
      if (ph == P_UNL) begin
        chk("m_valid", m_valid, 1'b1);
        chk("m_data", m_data, outq[0]);
        chk("m_last", m_last, outq.size() == 1);
      end else begin
        chk("m_valid", m_valid, 1'b0);
      end
      if (ph == P_RUN) begin
        chk("a_flat", a_flat, pack_a());
        chk("b_flat", b_flat, pack_b());
      end
    end
  end

  int act_cnt = 0;
  logic [127:0] a_snap;
  logic [71:0] b_snap;
  always @(negedge clk) begin
    if (active_sa3) begin
      act_cnt++;
      a_snap = a_flat;
      b_snap = b_flat;
    end
  end

  logic [7:0] rx [$];

  task automatic send_frame(input int n, input logic [7:0] first, input bit stall);
    bit hs;
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = 8'(first + i);
      s_last = (i == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 100);
      if (!hs) chk("s_handshake_bound", 1'b0, 1'b1);
      s_valid = 1'b0;
      s_last = 1'b0;
      if (stall) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input int st0, input int st1, input int st2, input int st3);
    int st [4];
    int t;
    st = '{st0, st1, st2, st3};
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!m_valid && t < 100);
      if (!m_valid) begin chk("m_valid_bound", 1'b0, 1'b1); return; end
      repeat (st[i]) begin @(posedge clk); #1; end
      rx.push_back(m_data);
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
  endtask

  task automatic chk_rx(input string name, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk(name, rx[i], e[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_active", active_sa3, 1'b0);
    chk("rst_a_flat", a_flat, 128'h0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal frame
    act_cnt = 0;
    send_frame(25, 8'h01, 1'b0);
    drain(0, 0, 0, 0);
    chk_rx("nom_rx", 8'h09, 8'h12, 8'h1B, 8'h24);
    chk("nom_active_cycles", act_cnt, 17);
    chk("nom_a_flat", a_snap, 128'h100F0E0D0C0B0A090807060504030201);
    chk("nom_b_flat", b_snap, 72'h191817161514131211);
    chk("nom_s_ready_after", s_ready, 1'b1);

    // Spurious done in LOAD, then framing error on byte 10
    spur = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    spur = 1'b0;
    send_frame(10, 8'h40, 1'b0);
    chk("frame_err_pulse", err_frame, 1'b1);
    @(posedge clk); #1;
    chk("frame_err_clear", err_frame, 1'b0);
    chk("frame_no_run", busy, 1'b0);
    stub_c = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(25, 8'h30, 1'b0);
    drain(0, 0, 0, 0);
    chk_rx("after_err_rx", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

    // Downstream backpressure
    stub_c = '{8'h09, 8'h12, 8'h1B, 8'h24};
    send_frame(25, 8'h50, 1'b0);
    drain(3, 0, 2, 0);
    chk_rx("bp_rx", 8'h09, 8'h12, 8'h1B, 8'h24);

    // Timeout, then a normal frame with err_timeout still sticky
    stub_en = 1'b0;
    act_cnt = 0;
    send_frame(25, 8'h01, 1'b0);
    drain(0, 0, 0, 0);
    chk_rx("to_rx", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("to_active_cycles", act_cnt, 31);
    chk("to_sticky", err_timeout, 1'b1);
    stub_en = 1'b1;
    send_frame(25, 8'h01, 1'b0);
    drain(0, 0, 0, 0);
    chk_rx("post_to_rx", 8'h09, 8'h12, 8'h1B, 8'h24);
    chk("post_to_sticky", err_timeout, 1'b1);

    // Async reset mid-run
    act_cnt = 0;
    send_frame(25, 8'h01, 1'b0);
    for (int t = 0; t < 100 && act_cnt < 8; t++) @(negedge clk);
    chk("rst_run_reached", act_cnt >= 8, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_active", active_sa3, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_s_ready", s_ready, 1'b1);
    chk("arst_err_timeout", err_timeout, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(25, 8'h01, 1'b0);
    drain(0, 0, 0, 0);
    chk_rx("post_rst_rx", 8'h09, 8'h12, 8'h1B, 8'h24);

    // Input stalls on every other cycle
    act_cnt = 0;
    send_frame(25, 8'h01, 1'b1);
    drain(0, 0, 0, 0);
    chk_rx("stall_rx", 8'h09, 8'h12, 8'h1B, 8'h24);
    chk("stall_a_flat", a_snap, 128'h100F0E0D0C0B0A090807060504030201);
    chk("stall_b_flat", b_snap, 72'h191817161514131211);
    chk("stall_active_cycles", act_cnt, 17);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/sa3_stream_bridge.md
Name: sa3_stream_bridge

Overview:
- Stream-side initiator/responder for the 3x3 systolic conv engine (4x4 image, 3x3 filter, 2x2 result).
- Accepts a 25-byte frame over a valid/ready byte stream: 16 image bytes, then 9 filter bytes.
- Presents the frame as held operand buses, runs the engine via its active/done handshake, captures the 2x2 result, and returns it as a 4-byte valid/ready stream.
- Sits between the DMA/byte-stream fabric and the systolic engine.

Parameters:
- DW, 8, data width of stream bytes, operands and results.
- TIMEOUT, 31, maximum RUN cycles without done before abort (must be >= 17).

Ports:
- clk  input  1  clock (already decided)
- rst  input  1  reset, asynchronous, active-high (already decided)
- s_valid  input  1  input byte valid
- s_ready  output  1  bridge accepts input byte
- s_data  input  DW  input byte
- s_last  input  1  marks final (25th) byte of frame
- m_valid  output  1  result byte valid
- m_ready  input  1  downstream accepts result byte
- m_data  output  DW  result byte
- m_last  output  1  marks 4th result byte
- active_sa3  output  1  engine run enable, held high for the whole run
- a_flat  output  16*DW  image; byte k (0..15) at bits [k*DW +: DW], row-major a11,a12..a44
- b_flat  output  9*DW  filter; byte k (0..8) at bits [k*DW +: DW], row-major b11..b33
- done_sa3  input  1  engine completion, one cycle, sampled on posedge
- c11, c12, c21, c22  input  DW each  engine results, valid when done_sa3=1
- busy  output  1  high in RUN and UNLOAD
- err_frame  output  1  one-cycle pulse on framing error
- err_timeout  output  1  sticky; set on run timeout, cleared only by rst

Behaviour:
- Reset (async): state=LOAD, byte count=0, run count=0. All outputs 0 except s_ready=1. a_flat, b_flat and captured results all 0. Reset mid-run drops active_sa3 immediately; the engine shares rst.
- LOAD:
  - s_ready=1, active_sa3=0, m_valid=0.
  - On s_valid&&s_ready: byte count k<16 writes a_flat slot k; k in 16..24 writes b_flat slot k-16; k increments.
  - Framing: s_last=1 with k<24, or s_last=0 with k=24, gives an err_frame pulse on the next cycle. k resets to 0 and the frame is discarded. Registers already written are not cleared; the next frame overwrites them.
  - Valid 25th byte (k=24, s_last=1): next state RUN, k=0.
- RUN:
  - s_ready=0, active_sa3=1 (registered), run count increments each cycle from 0.
  - a_flat and b_flat are held stable for the whole run.
  - The engine pulses done_sa3 on its 17th active cycle (run count=16).
  - On a clock edge with done_sa3=1: capture c11,c12,c21,c22; deassert active_sa3 on that edge; next state UNLOAD.
  - If run count reaches TIMEOUT with no done: set err_timeout, deassert active_sa3, force captured results to 0, go to UNLOAD (four zero bytes are still emitted).
- UNLOAD:
  - m_valid=1; m_data is a mux of captured regs by index j: 0=c11, 1=c12, 2=c21, 3=c22. m_last=(j==3).
  - On m_valid&&m_ready: j increments. After the j=3 transfer, next state LOAD, j=0.
  - m_data/m_last are stable while m_valid&&!m_ready; no byte is skipped or repeated.
  - s_ready=0 throughout UNLOAD, so input backpressure holds the next frame.
- busy=1 exactly when state is RUN or UNLOAD.
- done_sa3 outside RUN is ignored.
- Throughput: 25 (load) + 17 (run) + 4 (unload) = 46 cycles per frame minimum with no stalls.
- s_valid stalls in LOAD insert idle cycles only; byte count does not advance without a handshake.

Test Plan:
- Nominal frame with engine stub (done on 17th active cycle, c11..c22=0x09,0x12,0x1B,0x24) and image bytes 0x01..0x10, filter 0x11..0x19 -> a_flat/b_flat slots match row-major, active_sa3 high exactly 17 cycles, m_data sequence 09,12,1B,24 with m_last on 4th, s_ready back to 1 on the next cycle.
- Framing error: s_last on byte 10 -> err_frame pulse, no RUN. Then a clean 25-byte frame -> normal run and correct results.
- Downstream backpressure: m_ready low 3 cycles on byte 1 and 2 cycles on byte 3 -> m_data held stable, exact 4-byte order, no duplicates; s_ready=0 until the 4th transfer.
- Timeout: stub never asserts done -> active_sa3 drops after TIMEOUT=31 cycles, err_timeout=1 (sticky), four 0x00 bytes emitted, next frame runs normally with err_timeout still 1.
- Async reset asserted at run cycle 8 -> active_sa3, busy, m_valid go 0 immediately, s_ready=1. A following frame completes with correct results.
- Input stalls: s_valid toggled 1/0 every cycle across the frame -> identical operand buses and results to the nominal case. Spurious done_sa3 pulse during LOAD -> ignored.
